axi_console_fifo: RTL and testbench
===================================

AXI_CONSOLE_FIFO -- requirements
Module: axi_console_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving TX FIFO entries (power of two, 2..256).
REQ-002 The block SHALL have parameter PASS_VALUE, default 32'd123456789, the value that sets tests_passed.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port mem_axi_awvalid, input, 1 bit: write address valid.
REQ-006 The block SHALL have port mem_axi_awready, output, 1 bit: write address ready.
REQ-007 The block SHALL have port mem_axi_awaddr, input, 32 bits: write address; only bits [3:2] are decoded.
REQ-008 The block SHALL have port mem_axi_wvalid, input, 1 bit: write data valid.
REQ-009 The block SHALL have port mem_axi_wready, output, 1 bit: write data ready.
REQ-010 The block SHALL have port mem_axi_wdata, input, 32 bits: write data.
REQ-011 The block SHALL have port mem_axi_wstrb, input, 4 bits: byte strobes.
REQ-012 The block SHALL have port mem_axi_bvalid, output, 1 bit: write response valid.
REQ-013 The block SHALL have port mem_axi_bready, input, 1 bit: write response ready.
REQ-014 The block SHALL have port mem_axi_arvalid, input, 1 bit: read address valid.
REQ-015 The block SHALL have port mem_axi_arready, output, 1 bit: read address ready.
REQ-016 The block SHALL have port mem_axi_araddr, input, 32 bits: read address; only bits [3:2] are decoded.
REQ-017 The block SHALL have port mem_axi_rvalid, output, 1 bit: read data valid.
REQ-018 The block SHALL have port mem_axi_rready, input, 1 bit: read data ready.
REQ-019 The block SHALL have port mem_axi_rdata, output, 32 bits: read data.
REQ-020 The block SHALL have port tx_valid, output, 1 bit: equals !empty.
REQ-021 The block SHALL have port tx_data, output, 8 bits: the FIFO head byte.
REQ-022 The block SHALL have port tx_ready, input, 1 bit: the consumer pops the head when tx_valid and tx_ready are both high.
REQ-023 The block SHALL have port tests_passed, output, 1 bit: a sticky pass flag.

Function
REQ-024 Register map by addr[3:2] SHALL be:
- 0 = TXDATA, write-only; pushes wdata[7:0], and only when wstrb[0]=1.
- 1 = STATUS, read-only: bit0 empty, bit1 full, bit2 overflow_seen, bits[15:8] count.
- 2 = PASS, write-only; wdata==PASS_VALUE sets tests_passed.
- 3 = reserved; writes are ignored and read returns 0.
REQ-025 Write path handshakes SHALL be:
- awready SHALL be registered and pulse high for one cycle, the cycle after awvalid is seen with no address latched; wready SHALL behave the same for wvalid with no data latched.
- AW and W SHALL be accepted independently, in either order.
REQ-026 Write FSM SHALL have states IDLE -> COMMIT -> RESP -> IDLE.
- IDLE holds until both address and data are latched.
- COMMIT performs the register action.
- RESP holds bvalid high until bready, then clears both latches.
REQ-027 A TXDATA commit while the FIFO is full SHALL stall in COMMIT: no push, bvalid low, overflow_seen set; the push occurs on the first cycle the FIFO is not full.
REQ-028 With AW and W presented in the same cycle and the FIFO not full, bvalid SHALL rise exactly 3 cycles after awvalid/wvalid first go high.
REQ-029 Only one write SHALL be outstanding; no new AW/W is accepted while a write is latched or bvalid is high.
REQ-030 Read path SHALL behave as follows:
- arready pulses for one cycle, the cycle after arvalid, when rvalid is low.
- rvalid rises the following cycle with rdata captured at that edge.
- rdata and rvalid are held until rready.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH, with full = (count==DEPTH) and empty = (count==0).
REQ-032 A simultaneous push and pop SHALL leave count unchanged, and is legal only when not full.
REQ-033 tx_valid SHALL rise the cycle after the push edge; tx_data SHALL be stable while tx_valid is high and tx_ready is low.
REQ-034 tests_passed SHALL be sticky until reset; a PASS write of any other value SHALL not clear it.
REQ-035 Every write SHALL receive a bvalid response, including PASS, reserved, and TXDATA with wstrb[0]=0.

Reset
REQ-036 While resetn=0 at a clock edge, the block SHALL force:
- outputs: awready, wready, bvalid, arready, rvalid, tx_valid, tests_passed = 0; rdata = 0.
- FIFO: empty, count = 0, overflow_seen = 0.
- FSM: IDLE, with all latches cleared.
REQ-037 Reset mid-transaction SHALL abandon the transaction with no response, discard all FIFO contents, and restart at IDLE on the first edge with resetn=1.

Verification
REQ-038 Write TXDATA 0x41, strobe 0001, with tx_ready=1 -> bvalid 3 cycles later; tx_valid high for exactly one cycle with tx_data=0x41.
REQ-039 With tx_ready=0, write 17 bytes at DEPTH=16 -> the 17th write stalls with bvalid low and STATUS=0x1006 (count 16, full, overflow_seen); one tx_ready pulse completes it, and the final count is 16.
REQ-040 W presented 4 cycles before AW, to TXDATA -> exactly one push and one bvalid response.
REQ-041 Write PASS with 123456789 -> tests_passed=1; a subsequent PASS write of 0 keeps it at 1; reset clears it.
REQ-042 Push 16 bytes, then simultaneously push and pop for 40 cycles across pointer wrap -> output order is preserved and count stays 15 or 16.
REQ-043 Assert resetn=0 while in RESP with 5 bytes queued -> the next cycle shows empty, bvalid=0, and STATUS reads 0x0001.

Source files
------------

// File: rtl/axi_console_fifo.sv
// AXI4-lite console: a byte-wide TX FIFO fed by register writes, a STATUS register,
// and a sticky pass flag set by writing a magic value.
module axi_console_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter logic [31:0] PASS_VALUE = 32'd123456789
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,

  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,

  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,

  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,

  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,

  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,

  output logic        tests_passed
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  localparam logic [1:0] SelTxData = 2'd0;
  localparam logic [1:0] SelStatus = 2'd1;
  localparam logic [1:0] SelPass   = 2'd2;

  typedef enum logic [1:0] {StIdle, StCommit, StResp} wr_state_e;

  wr_state_e state_q, state_d;

  // Write address / data latches
  logic        aw_ready_q, aw_valid_q;
  logic [1:0]  aw_sel_q;
  logic        w_ready_q, w_valid_q;
  logic [31:0] w_data_q;
  logic        w_strb0_q;
  logic        aw_hs, w_hs;

  // FIFO state
  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            overflow_q;
  logic            passed_q;
  logic            fifo_full, fifo_empty;
  logic            push, pop;

  // Write FSM decoded actions
  logic resp, stall, commit_tx, commit_pass;

  // Read path
  logic        ar_ready_q, rvalid_q;
  logic [31:0] rdata_q, rd_word;
  logic [7:0]  status_cnt;

  logic unused_bits;
  assign unused_bits = ^{mem_axi_awaddr[31:4], mem_axi_awaddr[1:0],
                         mem_axi_araddr[31:4], mem_axi_araddr[1:0], mem_axi_wstrb[3:1]};

  assign aw_hs      = mem_axi_awvalid & aw_ready_q;
  assign w_hs       = mem_axi_wvalid & w_ready_q;
  assign fifo_full  = (count_q == CntW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = commit_tx;
  assign pop        = ~fifo_empty & tx_ready;
  // Count field is 8 bits wide; at DEPTH=256 a full FIFO reads back as 0 with full set.
  assign status_cnt = 8'(count_q);

  // AW/W acceptance: one-cycle ready pulses, only while idle with nothing latched
  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_ready_q <= 1'b0;
      aw_valid_q <= 1'b0;
      aw_sel_q   <= 2'd0;
      w_ready_q  <= 1'b0;
      w_valid_q  <= 1'b0;
      w_data_q   <= 32'd0;
      w_strb0_q  <= 1'b0;
    end else begin
      aw_ready_q <= mem_axi_awvalid & ~aw_valid_q & ~aw_ready_q & (state_q == StIdle);
      w_ready_q  <= mem_axi_wvalid & ~w_valid_q & ~w_ready_q & (state_q == StIdle);
      if (aw_hs) begin
        aw_valid_q <= 1'b1;
        aw_sel_q   <= mem_axi_awaddr[3:2];
      end
      if (w_hs) begin
        w_valid_q <= 1'b1;
        w_data_q  <= mem_axi_wdata;
        w_strb0_q <= mem_axi_wstrb[0];
      end
      if (resp && mem_axi_bready) begin
        aw_valid_q <= 1'b0;
        w_valid_q  <= 1'b0;
      end
    end
  end

  // Write FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Write FSM next state; a handshake on the same edge counts as latched
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if ((aw_valid_q | aw_hs) & (w_valid_q | w_hs)) state_d = StCommit;
      StCommit: if (!stall) state_d = StResp;
      StResp:   if (mem_axi_bready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Write FSM outputs: register action in COMMIT, response in RESP
  always_comb begin
    resp        = 1'b0;
    stall       = 1'b0;
    commit_tx   = 1'b0;
    commit_pass = 1'b0;
    unique case (state_q)
      StCommit: begin
        if (aw_sel_q == SelTxData && w_strb0_q) begin
          if (fifo_full) stall = 1'b1;
          else           commit_tx = 1'b1;
        end
        if (aw_sel_q == SelPass && w_data_q == PASS_VALUE) commit_pass = 1'b1;
      end
      StResp:  resp = 1'b1;
      default: ;
    endcase
  end

  // FIFO pointers, occupancy and overflow flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
      if (stall) overflow_q <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care once pointers reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= w_data_q[7:0];
  end

  // Sticky pass flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      passed_q <= 1'b0;
    end else if (commit_pass) begin
      passed_q <= 1'b1;
    end
  end

  // Read data mux; only STATUS is readable
  always_comb begin
    rd_word = 32'd0;
    unique case (mem_axi_araddr[3:2])
      SelStatus: rd_word = {16'd0, status_cnt, 5'd0, overflow_q, fifo_full, fifo_empty};
      default:   rd_word = 32'd0;
    endcase
  end

  // Read channel: arready pulse, then rdata/rvalid captured on the handshake edge
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ar_ready_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      ar_ready_q <= mem_axi_arvalid & ~ar_ready_q & ~rvalid_q;
      if (mem_axi_arvalid && ar_ready_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
      end else if (rvalid_q && mem_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign mem_axi_awready = aw_ready_q;
  assign mem_axi_wready  = w_ready_q;
  assign mem_axi_bvalid  = resp;
  assign mem_axi_arready = ar_ready_q;
  assign mem_axi_rvalid  = rvalid_q;
  assign mem_axi_rdata   = rdata_q;
  assign tx_valid        = ~fifo_empty;
  assign tx_data         = mem_q[rd_ptr_q];
  assign tests_passed    = passed_q;

endmodule

// File: tb/tb_axi_console_fifo.sv
// Directed bench for axi_console_fifo at DEPTH=16.
module tb_axi_console_fifo;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_axi_awvalid = 1'b0;
  logic        mem_axi_awready;
  logic [31:0] mem_axi_awaddr = '0;
  logic        mem_axi_wvalid = 1'b0;
  logic        mem_axi_wready;
  logic [31:0] mem_axi_wdata = '0;
  logic [3:0]  mem_axi_wstrb = '0;
  logic        mem_axi_bvalid;
  logic        mem_axi_bready = 1'b0;
  logic        mem_axi_arvalid = 1'b0;
  logic        mem_axi_arready;
  logic [31:0] mem_axi_araddr = '0;
  logic        mem_axi_rvalid;
  logic        mem_axi_rready = 1'b0;
  logic [31:0] mem_axi_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        tests_passed;

  int checks = 0;
  int failures = 0;

  logic [7:0] popped[$];
  int         txv_cycles = 0;
  int         b_count = 0;

  always #5 clk = ~clk;

  axi_console_fifo #(
    .DEPTH(16),
    .PASS_VALUE(32'd123456789)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .mem_axi_awvalid(mem_axi_awvalid),
    .mem_axi_awready(mem_axi_awready),
    .mem_axi_awaddr(mem_axi_awaddr),
    .mem_axi_wvalid(mem_axi_wvalid),
    .mem_axi_wready(mem_axi_wready),
    .mem_axi_wdata(mem_axi_wdata),
    .mem_axi_wstrb(mem_axi_wstrb),
    .mem_axi_bvalid(mem_axi_bvalid),
    .mem_axi_bready(mem_axi_bready),
    .mem_axi_arvalid(mem_axi_arvalid),
    .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr),
    .mem_axi_rvalid(mem_axi_rvalid),
    .mem_axi_rready(mem_axi_rready),
    .mem_axi_rdata(mem_axi_rdata),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .tests_passed(tests_passed)
  );

  // Consumer-side monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (resetn) begin
      if (tx_valid) txv_cycles <= txv_cycles + 1;
      if (tx_valid && tx_ready) popped.push_back(tx_data);
      if (mem_axi_bvalid && mem_axi_bready) b_count <= b_count + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    mem_axi_awvalid = 1'b0;
    mem_axi_wvalid = 1'b0;
    mem_axi_arvalid = 1'b0;
    mem_axi_bready = 1'b0;
    mem_axi_rready = 1'b0;
    tx_ready = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output int cyc);
    logic a, w;
    mem_axi_awaddr = addr;
    mem_axi_wdata = data;
    mem_axi_wstrb = strb;
    mem_axi_awvalid = 1'b1;
    mem_axi_wvalid = 1'b1;
    cyc = 0;
    while ((mem_axi_awvalid || mem_axi_wvalid) && cyc < 50) begin
      a = mem_axi_awready;
      w = mem_axi_wready;
      tick();
      cyc++;
      if (a) mem_axi_awvalid = 1'b0;
      if (w) mem_axi_wvalid = 1'b0;
    end
    checks++;
    if (mem_axi_awvalid || mem_axi_wvalid) begin
      failures++;
      $display("FAIL aw_w_accept: still pending after %0d cycles, required within 50", cyc);
    end
    mem_axi_awvalid = 1'b0;
    mem_axi_wvalid = 1'b0;
  endtask

  task automatic wait_b(input int budget, input bit ack, output int n, output bit got);
    n = 0;
    while (!mem_axi_bvalid && n < budget) begin
      tick();
      n++;
    end
    got = mem_axi_bvalid;
    if (got && ack) begin
      mem_axi_bready = 1'b1;
      tick();
      mem_axi_bready = 1'b0;
    end
  endtask

  task automatic write_reg(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output int lat);
    int c, n;
    bit got;
    send_aw_w(addr, data, strb, c);
    wait_b(10, 1'b1, n, got);
    lat = c + n;
    checks++;
    if (got !== 1'b1) begin
      failures++;
      $display("FAIL bresp addr=%h: bvalid=%b, required 1 within 10 cycles", addr, got);
    end
  endtask

  task automatic read_reg(input logic [31:0] addr, output logic [31:0] data);
    int n;
    logic a;
    mem_axi_araddr = addr;
    mem_axi_arvalid = 1'b1;
    n = 0;
    while (mem_axi_arvalid && n < 20) begin
      a = mem_axi_arready;
      tick();
      n++;
      if (a) mem_axi_arvalid = 1'b0;
    end
    mem_axi_arvalid = 1'b0;
    n = 0;
    while (!mem_axi_rvalid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (mem_axi_rvalid !== 1'b1) begin
      failures++;
      $display("FAIL read_rvalid addr=%h: rvalid=%b, required 1", addr, mem_axi_rvalid);
    end
    data = mem_axi_rdata;
    mem_axi_rready = 1'b1;
    tick();
    mem_axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [6:0]  ctl;
    resetn = 1'b0;
    mem_axi_awvalid = 1'b1;
    mem_axi_wvalid = 1'b1;
    mem_axi_arvalid = 1'b1;
    tick();
    tick();
    ctl = {mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_arready,
           mem_axi_rvalid, tx_valid, tests_passed};
    checks++;
    if (ctl !== 7'd0) begin
      failures++;
      $display("FAIL reset_ctrl: outputs=%b, required 0000000", ctl);
    end
    checks++;
    if (mem_axi_rdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_rdata: rdata=%h, required 00000000", mem_axi_rdata);
    end
    mem_axi_awvalid = 1'b0;
    mem_axi_wvalid = 1'b0;
    mem_axi_arvalid = 1'b0;
    resetn = 1'b1;
    tick();
    read_reg(32'h4, d);
    checks++;
    if (d !== 32'h0000_0001) begin
      failures++;
      $display("FAIL reset_status: status=%h, required 00000001", d);
    end
  endtask

  task automatic test_txdata_single();
    int c, n, base, tv0;
    bit got;
    do_reset();
    tx_ready = 1'b1;
    base = popped.size();
    tv0 = txv_cycles;
    send_aw_w(32'h0, 32'h41, 4'b0001, c);
    wait_b(10, 1'b0, n, got);
    checks++;
    if (c + n !== 3) begin
      failures++;
      $display("FAIL b_latency: bvalid after %0d cycles, required 3", c + n);
    end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
      failures++;
      $display("FAIL tx_head: tx_valid=%b tx_data=%h, required 1/41", tx_valid, tx_data);
    end
    mem_axi_bready = 1'b1;
    tick();
    mem_axi_bready = 1'b0;
    repeat (3) tick();
    checks++;
    if (txv_cycles - tv0 !== 1) begin
      failures++;
      $display("FAIL tx_valid_width: high %0d cycles, required 1", txv_cycles - tv0);
    end
    checks++;
    if (popped.size() - base !== 1 || popped[base] !== 8'h41) begin
      failures++;
      $display("FAIL tx_pop: %0d bytes popped, required one byte 41", popped.size() - base);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int c, n, lat, base;
    bit got;
    logic [31:0] d;
    logic [7:0]  exp_b;
    do_reset();
    base = popped.size();
    for (int i = 0; i < 16; i++) write_reg(32'h0, 32'h10 + i, 4'b0001, lat);
    read_reg(32'h4, d);
    checks++;
    if (d !== 32'h0000_1002) begin
      failures++;
      $display("FAIL full_status: status=%h, required 00001002", d);
    end
    send_aw_w(32'h0, 32'h99, 4'b0001, c);
    wait_b(6, 1'b0, n, got);
    checks++;
    if (got !== 1'b0) begin
      failures++;
      $display("FAIL stall_bvalid: bvalid=%b while full, required 0", got);
    end
    read_reg(32'h4, d);
    checks++;
    if (d !== 32'h0000_1006) begin
      failures++;
      $display("FAIL stall_status: status=%h, required 00001006", d);
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    wait_b(6, 1'b1, n, got);
    checks++;
    if (got !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: bvalid=%b after pop, required 1", got);
    end
    read_reg(32'h4, d);
    checks++;
    if (d !== 32'h0000_1006) begin
      failures++;
      $display("FAIL refill_status: status=%h, required 00001006", d);
    end
    tx_ready = 1'b1;
    repeat (20) tick();
    tx_ready = 1'b0;
    checks++;
    if (popped.size() - base !== 17) begin
      failures++;
      $display("FAIL overflow_count: %0d bytes popped, required 17", popped.size() - base);
    end
    for (int j = 0; j < 17 && base + j < popped.size(); j++) begin
      exp_b = (j < 16) ? 8'(8'h10 + j) : 8'h99;
      checks++;
      if (popped[base + j] !== exp_b) begin
        failures++;
        $display("FAIL overflow_order[%0d]: byte=%h, required %h", j, popped[base + j], exp_b);
      end
    end
    read_reg(32'h4, d);
    checks++;
    if (d !== 32'h0000_0005) begin
      failures++;
      $display("FAIL drained_status: status=%h, required 00000005", d);
    end
  endtask

  task automatic test_w_before_aw();
    int n, b0, base;
    bit got;
    logic a, w;
    logic [31:0] d;
    do_reset();
    b0 = b_count;
    base = popped.size();
    mem_axi_wdata = 32'h5A;
    mem_axi_wstrb = 4'b0001;
    mem_axi_awaddr = 32'h0;
    mem_axi_wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = mem_axi_wready;
      tick();
      if (w) mem_axi_wvalid = 1'b0;
    end
    mem_axi_wvalid = 1'b0;
    mem_axi_awvalid = 1'b1;
    n = 0;
    while (mem_axi_awvalid && n < 20) begin
      a = mem_axi_awready;
      tick();
      n++;
      if (a) mem_axi_awvalid = 1'b0;
    end
    mem_axi_awvalid = 1'b0;
    wait_b(10, 1'b1, n, got);
    repeat (4) tick();
    checks++;
    if (b_count - b0 !== 1) begin
      failures++;
      $display("FAIL w_first_bresp: %0d responses, required 1", b_count - b0);
    end
    read_reg(32'h4, d);
    checks++;
    if (d !== 32'h0000_0100) begin
      failures++;
      $display("FAIL w_first_status: status=%h, required 00000100", d);
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    tick();
    checks++;
    if (popped.size() - base !== 1 || popped[base] !== 8'h5A) begin
      failures++;
      $display("FAIL w_first_data: %0d bytes popped, required one byte 5a", popped.size() - base);
    end
  endtask

  task automatic test_pass();
    int lat;
    logic [31:0] d;
    do_reset();
    write_reg(32'h8, 32'd123456788, 4'hF, lat);
    checks++;
    if (tests_passed !== 1'b0) begin
      failures++;
      $display("FAIL pass_wrong: tests_passed=%b, required 0", tests_passed);
    end
    write_reg(32'h8, 32'd123456789, 4'hF, lat);
    checks++;
    if (tests_passed !== 1'b1) begin
      failures++;
      $display("FAIL pass_set: tests_passed=%b, required 1", tests_passed);
    end
    write_reg(32'h8, 32'd0, 4'hF, lat);
    checks++;
    if (tests_passed !== 1'b1) begin
      failures++;
      $display("FAIL pass_sticky: tests_passed=%b, required 1", tests_passed);
    end
    write_reg(32'hC, 32'hDEAD, 4'hF, lat);
    read_reg(32'hC, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL reserved_read: rdata=%h, required 00000000", d);
    end
    read_reg(32'h8, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL pass_read: rdata=%h, required 00000000", d);
    end
    write_reg(32'h0, 32'h33, 4'b0010, lat);
    read_reg(32'h4, d);
    checks++;
    if (d !== 32'h0000_0001) begin
      failures++;
      $display("FAIL nostrobe_status: status=%h, required 00000001", d);
    end
    do_reset();
    checks++;
    if (tests_passed !== 1'b0) begin
      failures++;
      $display("FAIL pass_reset: tests_passed=%b, required 0", tests_passed);
    end
  endtask

  task automatic test_back_to_back();
    int c, n, lat, base;
    bit got;
    logic [31:0] d;
    logic [7:0]  exp_q[$];
    do_reset();
    base = popped.size();
    for (int i = 0; i < 16; i++) begin
      write_reg(32'h0, 32'(i), 4'b0001, lat);
      exp_q.push_back(8'(i));
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      send_aw_w(32'h0, 32'h80 + k, 4'b0001, c);
      exp_q.push_back(8'(8'h80 + k));
      // Pop during the commit cycle so push and pop land on the same edge
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      wait_b(5, 1'b1, n, got);
      read_reg(32'h4, d);
      checks++;
      if (d !== 32'h0000_0F00) begin
        failures++;
        $display("FAIL b2b_status[%0d]: status=%h, required 00000f00", k, d);
      end
    end
    tx_ready = 1'b1;
    repeat (20) tick();
    tx_ready = 1'b0;
    checks++;
    if (popped.size() - base !== exp_q.size()) begin
      failures++;
      $display("FAIL b2b_count: %0d bytes popped, required %0d", popped.size() - base,
               exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && base + j < popped.size(); j++) begin
      checks++;
      if (popped[base + j] !== exp_q[j]) begin
        failures++;
        $display("FAIL b2b_order[%0d]: byte=%h, required %h", j, popped[base + j], exp_q[j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int c, n, lat, b0;
    bit got;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 5; i++) write_reg(32'h0, 32'h60 + i, 4'b0001, lat);
    b0 = b_count;
    send_aw_w(32'h8, 32'd0, 4'hF, c);
    wait_b(10, 1'b0, n, got);
    checks++;
    if (got !== 1'b1) begin
      failures++;
      $display("FAIL mid_resp: bvalid=%b, required 1 before reset", got);
    end
    resetn = 1'b0;
    tick();
    checks++;
    if (tx_valid !== 1'b0 || mem_axi_bvalid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: tx_valid=%b bvalid=%b, required 0/0", tx_valid, mem_axi_bvalid);
    end
    resetn = 1'b1;
    tick();
    read_reg(32'h4, d);
    checks++;
    if (d !== 32'h0000_0001) begin
      failures++;
      $display("FAIL mid_status: status=%h, required 00000001", d);
    end
    checks++;
    if (b_count - b0 !== 0) begin
      failures++;
      $display("FAIL mid_abandon: %0d responses, required 0", b_count - b0);
    end
    write_reg(32'h0, 32'h77, 4'b0001, lat);
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL mid_restart_latency: %0d cycles, required 3", lat);
    end
    read_reg(32'h4, d);
    checks++;
    if (d !== 32'h0000_0100) begin
      failures++;
      $display("FAIL mid_restart_status: status=%h, required 00000100", d);
    end
  endtask

  initial begin
    test_reset();
    test_txdata_single();
    test_overflow();
    test_w_before_aw();
    test_pass();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
